// File: rtl/rc4_mem_sequencer.sv
// Sequences the init, shuffle and decrypt engines of an RC4 cracker over one shared S-memory.
// Define RC4_KEY_SEARCH_EN to retry failed decrypts with successive keys up to KEY_LAST.
module rc4_mem_sequencer #(
    parameter logic [23:0] KEY_LAST = 24'h3FFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] key_in,
    output logic [2:0]  eng_start,
    input  logic [2:0]  eng_finish,
    input  logic        dec_fail,
    input  logic [23:0] eng_addr,
    input  logic [23:0] eng_data,
    input  logic [2:0]  eng_wen,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_data,
    output logic        s_wen,
    output logic [23:0] secret_key,
    output logic        busy,
    output logic        done,
    output logic        fail
);

    typedef enum logic [3:0] {
        IDLE,
        INIT_GO,
        INIT_WAIT,
        SHUF_GO,
        SHUF_WAIT,
        DEC_GO,
        DEC_WAIT,
`ifdef RC4_KEY_SEARCH_EN
        NEXT_KEY,
`endif
        DONE,
        FAIL
    } state_t;

    state_t     state;
    logic [2:0] fin_q;
    logic [2:0] fin_rise;

    // Engines may hold finish high; only a fresh 0->1 transition counts as completion.
    assign fin_rise = eng_finish & ~fin_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            eng_start  <= '0;
            secret_key <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            fin_q      <= '0;
        end else begin
            fin_q     <= eng_finish;
            eng_start <= '0;
            case (state)
                IDLE, DONE, FAIL: begin
                    if (start) begin
                        state      <= INIT_GO;
                        secret_key <= key_in;
                        eng_start  <= 3'b001;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        fail       <= 1'b0;
                    end
                end
                INIT_GO: state <= INIT_WAIT;
                INIT_WAIT: begin
                    if (fin_rise[0]) begin
                        state     <= SHUF_GO;
                        eng_start <= 3'b010;
                    end
                end
                SHUF_GO: state <= SHUF_WAIT;
                SHUF_WAIT: begin
                    if (fin_rise[1]) begin
                        state     <= DEC_GO;
                        eng_start <= 3'b100;
                    end
                end
                DEC_GO: state <= DEC_WAIT;
                DEC_WAIT: begin
                    if (fin_rise[2]) begin
                        if (!dec_fail) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
`ifdef RC4_KEY_SEARCH_EN
                        else if (secret_key != KEY_LAST) begin
                            state <= NEXT_KEY;
                        end
`endif
                        else begin
                            state <= FAIL;
                            busy  <= 1'b0;
                            fail  <= 1'b1;
                        end
                    end
                end
`ifdef RC4_KEY_SEARCH_EN
                NEXT_KEY: begin
                    secret_key <= secret_key + 24'd1;
                    state      <= INIT_GO;
                    eng_start  <= 3'b001;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_addr = '0;
        s_data = '0;
        s_wen  = 1'b0;
        case (state)
            INIT_GO, INIT_WAIT: begin
                s_addr = eng_addr[7:0];
                s_data = eng_data[7:0];
                s_wen  = eng_wen[0];
            end
            SHUF_GO, SHUF_WAIT: begin
                s_addr = eng_addr[15:8];
                s_data = eng_data[15:8];
                s_wen  = eng_wen[1];
            end
            DEC_GO, DEC_WAIT: begin
                s_addr = eng_addr[23:16];
                s_data = eng_data[23:16];
                s_wen  = eng_wen[2];
            end
            default: ;
        endcase
    end

endmodule

// File: doc/rc4_mem_sequencer.md
RC4_MEM_SEQUENCER -- requirements
Module: rc4_mem_sequencer

Interface
REQ-001 SHALL have parameter KEY_LAST, default 24'h3FFFFF, meaning the last key tried in key search.
REQ-002 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port start  in  1  single-cycle request to begin a decryption run.
REQ-005 SHALL have port key_in  in  24  initial secret key.
REQ-006 SHALL have port eng_start  out  3  one-cycle start pulse per engine; bit0 init, bit1 shuffle, bit2 decrypt.
REQ-007 SHALL have port eng_finish  in  3  per-engine finish flag, possibly sticky.
REQ-008 SHALL have port dec_fail  in  1  decrypt engine's verdict, valid with bit2 of eng_finish.
REQ-009 SHALL have port eng_addr  in  24  packed per-engine S-memory address, engine k in bits [8k+7:8k].
REQ-010 SHALL have port eng_data  in  24  packed per-engine S-memory write data, same packing.
REQ-011 SHALL have port eng_wen  in  3  per-engine S-memory write enable.
REQ-012 SHALL have port s_addr  out  8  shared S-memory address.
REQ-013 SHALL have port s_data  out  8  shared S-memory write data.
REQ-014 SHALL have port s_wen  out  1  shared S-memory write enable.
REQ-015 SHALL have port secret_key  out  24  key currently applied to the engines.
REQ-016 SHALL have port busy  out  1  high from the cycle after an accepted start until DONE or FAIL.
REQ-017 SHALL have port done  out  1  high while in DONE.
REQ-018 SHALL have port fail  out  1  high while in FAIL.

Function
REQ-019 SHALL use states IDLE, INIT_GO, INIT_WAIT, SHUF_GO, SHUF_WAIT, DEC_GO, DEC_WAIT, NEXT_KEY, DONE and FAIL.
REQ-020 SHALL accept start only in IDLE, DONE or FAIL: load secret_key from key_in and enter INIT_GO next cycle; start SHALL be ignored in all other states.
REQ-021 SHALL assert eng_start[k] for exactly one cycle in the matching GO state, then move to the matching WAIT state.
REQ-022 SHALL register eng_finish each cycle and, in a WAIT state, advance only on a rising edge of the matching bit (current 1, previous 0), so a stale sticky finish is never taken as completion.
REQ-023 SHALL step INIT_WAIT -> SHUF_GO -> SHUF_WAIT -> DEC_GO -> DEC_WAIT on those edges.
REQ-024 SHALL, in DEC_WAIT on a bit2 rising edge, go to DONE if dec_fail=0, else handle failure per REQ-031/032.
REQ-025 SHALL drive s_addr, s_data and s_wen combinationally from engine 0 in INIT_*, engine 1 in SHUF_*, and engine 2 in DEC_*.
REQ-026 SHALL, in IDLE, NEXT_KEY, DONE and FAIL, force s_wen=0, s_addr=0 and s_data=0; only one engine ever drives s_wen.
REQ-027 SHALL ignore finish edges of non-selected engines.
REQ-028 SHALL keep secret_key stable from INIT_GO through DEC_WAIT of a run.

Reset
REQ-029 SHALL, on reset high at a clock edge in any state, enter IDLE with eng_start=0, s_wen=0, s_addr=0, s_data=0, secret_key=0, busy=0, done=0, fail=0 and the finish history cleared; reset overrides a simultaneous start.
REQ-030 SHALL abandon a run on mid-run reset without pulsing any eng_start.

Configuration
REQ-031 SHALL, with macro RC4_KEY_SEARCH_EN defined, on a failed decrypt go to NEXT_KEY if secret_key != KEY_LAST, increment secret_key by 1 (24-bit), then enter INIT_GO; if secret_key == KEY_LAST it SHALL go to FAIL.
REQ-032 SHALL, without RC4_KEY_SEARCH_EN, go directly from a failed decrypt to FAIL with secret_key unchanged and no NEXT_KEY state.

Verification
REQ-033 SHALL be verified for a pass run: key_in=24'h000249, start, engines finish with dec_fail=0 -> eng_start pulses 001, 010, 100 in order; done=1; secret_key=24'h000249.
REQ-034 SHALL be verified for a sticky finish: eng_finish[1] held 1 before SHUF_GO -> sequencer stays in SHUF_WAIT until bit1 falls and rises again.
REQ-035 SHALL be verified for key search (macro on): key_in=24'h000010, dec_fail=1 twice then 0 -> init restarts twice; done with secret_key=24'h000012.
REQ-036 SHALL be verified for exhaustion (macro on, KEY_LAST=24'h000003): key_in=24'h000002, dec_fail always 1 -> fail=1 with secret_key=24'h000003; with the macro off -> fail=1 after the first run.
REQ-037 SHALL be verified for a mid-run reset: reset during SHUF_WAIT -> next cycle IDLE, s_wen=0, busy=0; a later start runs normally.
REQ-038 SHALL be verified for muxing: engine 0 drives eng_wen=3'b011 during INIT_WAIT -> s_wen follows bit0 only, s_addr=eng_addr[7:0].
